bringup_uart_checker: RTL and testbench

- Downstream consumer of the level-shifter bringup pattern generator: decodes the 115200-baud 8N1 byte stream looped back from one shifted pin and compares each byte against that pin's expected signature.
- Counts matches, mismatches and framing errors, and flags whether a correct byte arrived recently.
- One instance per looped-back pin. The bringup top exposes counters and flags on debug outputs or LEDs.

---
 rtl/bringup_uart_checker.sv | 274 +++++++++++++++++++++++++++
 tb/tb_bringup_uart_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bringup_uart_checker.sv
// -----------------------------------------------------------------------------
// bringup_uart_checker
//
// Receives the 8N1 byte stream looped back from one level-shifted pin and
// compares every correctly framed byte with the signature expected on that
// pin. Keeps saturating match / mismatch / framing-error counters, a sticky
// framing-error flag and an "alive" flag that stays high while a matching
// byte has been seen within the last TIMEOUT_CLOCKS clocks.
//
// Optional feature macro: BRINGUP_UART_CHECKER_STUCK_DETECT_EN
//   defined   -> a low-time counter drives stuck_low_o after 20 bit periods
//                of continuous low line
//   undefined -> stuck_low_o is tied to 0
//
// Parameters:
//   CLOCKS_PER_BAUD  clocks per bit period (must be >= 4)
//   EXPECTED         signature byte for this pin
//   TIMEOUT_CLOCKS   clocks without a match before alive_o drops
//
// Ports:
//   clock             system clock
//   reset             synchronous, active-high reset
//   rx_i              asynchronous serial input, idle high
//   clear_i           synchronous clear of counters and frame_error_o
//   byte_valid_o      one-cycle strobe, frame with valid stop bit received
//   byte_o            last valid byte, held until the next valid frame
//   match_o           one-cycle strobe with byte_valid_o when byte == EXPECTED
//   frame_error_o     sticky, a stop bit was sampled low
//   match_count_o     saturating count of matching bytes
//   mismatch_count_o  saturating count of valid non-matching bytes
//   error_count_o     saturating count of framing errors
//   alive_o           a match occurred within the last TIMEOUT_CLOCKS clocks
//   stuck_low_o       line held low for 20 bit periods (optional feature)
// -----------------------------------------------------------------------------
module bringup_uart_checker #(
    parameter int unsigned CLOCKS_PER_BAUD = 104,
    parameter logic [7:0]  EXPECTED        = 8'h45,
    parameter int unsigned TIMEOUT_CLOCKS  = 240000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_i,
    input  logic        clear_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    output logic        match_o,
    output logic        frame_error_o,
    output logic [15:0] match_count_o,
    output logic [15:0] mismatch_count_o,
    output logic [15:0] error_count_o,
    output logic        alive_o,
    output logic        stuck_low_o
);

    localparam int unsigned       BAUD_W    = $clog2(CLOCKS_PER_BAUD);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLOCKS_PER_BAUD - 1);
    localparam int unsigned       TO_W      = $clog2(TIMEOUT_CLOCKS + 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CLOCKS);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLOCKS - 1);
    localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_sync;
    logic                w_rx_s;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_next;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                w_stop_ok;
    logic                w_stop_bad;
    logic                w_is_match;

    logic                r_byte_valid;
    logic [7:0]          r_byte;
    logic                r_match;
    logic                r_frame_error;
    logic [15:0]         r_match_count;
    logic [15:0]         r_mismatch_count;
    logic [15:0]         r_error_count;
    logic [TO_W-1:0]     r_timeout;
    logic                r_alive;

    assign w_rx_s     = r_sync[1];
    assign w_is_match = (r_shift == EXPECTED);

    // Synchronizer resets to the idle (high) level so reset never looks
    // like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + BAUD_W'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // Half-bit check rejects short glitches and centres the
                // following data samples in their bit cells.
                if (r_baud == HALF_LAST) begin
                    w_baud_next = '0;
                    if (w_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_bit_next   = '0;
                    end
                end
            end
            S_DATA: begin
                if (r_baud == BIT_LAST) begin
                    w_baud_next  = '0;
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_baud == BIT_LAST) begin
                    w_baud_next = '0;
                    if (w_rx_s) begin
                        w_state_next = S_IDLE;
                        w_stop_ok    = 1'b1;
                    end else begin
                        w_state_next = S_BREAK;
                        w_stop_bad   = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it is counted only once.
                w_baud_next = '0;
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    // Result strobes, held byte, counters. Clear takes priority over any
    // increment arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_valid     <= 1'b0;
            r_byte           <= '0;
            r_match          <= 1'b0;
            r_frame_error    <= 1'b0;
            r_match_count    <= '0;
            r_mismatch_count <= '0;
            r_error_count    <= '0;
        end else begin
            r_byte_valid <= w_stop_ok;
            r_match      <= w_stop_ok && w_is_match;
            if (w_stop_ok) begin
                r_byte <= r_shift;
            end
            if (clear_i) begin
                r_frame_error    <= 1'b0;
                r_match_count    <= '0;
                r_mismatch_count <= '0;
                r_error_count    <= '0;
            end else begin
                if (w_stop_ok && w_is_match && (r_match_count != CNT_MAX)) begin
                    r_match_count <= r_match_count + 16'd1;
                end
                if (w_stop_ok && !w_is_match && (r_mismatch_count != CNT_MAX)) begin
                    r_mismatch_count <= r_mismatch_count + 16'd1;
                end
                if (w_stop_bad) begin
                    r_frame_error <= 1'b1;
                    if (r_error_count != CNT_MAX) begin
                        r_error_count <= r_error_count + 16'd1;
                    end
                end
            end
        end
    end

    // Activity timer restarts on the match strobe, so alive_o rises the
    // cycle after match_o and stays high for exactly TIMEOUT_CLOCKS cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout <= '0;
            r_alive   <= 1'b0;
        end else if (r_match) begin
            r_timeout <= '0;
            r_alive   <= 1'b1;
        end else if (r_timeout != TO_MAX) begin
            r_timeout <= r_timeout + TO_W'(1);
            if (r_timeout == TO_LAST) begin
                r_alive <= 1'b0;
            end
        end
    end

`ifdef BRINGUP_UART_CHECKER_STUCK_DETECT_EN
    localparam int unsigned     STUCK_CLOCKS = 20 * CLOCKS_PER_BAUD;
    localparam int unsigned     LOW_W        = $clog2(STUCK_CLOCKS + 1);
    localparam logic [LOW_W-1:0] LOW_MAX     = LOW_W'(STUCK_CLOCKS);

    logic [LOW_W-1:0] r_low_count;

    // Saturates at the threshold so stuck_low_o holds until the line rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_low_count <= '0;
        end else if (w_rx_s) begin
            r_low_count <= '0;
        end else if (r_low_count != LOW_MAX) begin
            r_low_count <= r_low_count + LOW_W'(1);
        end
    end

    assign stuck_low_o = (r_low_count == LOW_MAX);
`else
    assign stuck_low_o = 1'b0;
`endif

    assign byte_valid_o     = r_byte_valid;
    assign byte_o           = r_byte;
    assign match_o          = r_match;
    assign frame_error_o    = r_frame_error;
    assign match_count_o    = r_match_count;
    assign mismatch_count_o = r_mismatch_count;
    assign error_count_o    = r_error_count;
    assign alive_o          = r_alive;

endmodule

// File: tb/tb_bringup_uart_checker.sv
// -----------------------------------------------------------------------------
// tb_bringup_uart_checker
//
// Drives 8N1 frames into bringup_uart_checker (scaled-down bit period and
// timeout) and compares strobes, latency, held byte, counters, sticky flag,
// alive_o and stuck_low_o against expectations derived from the frames sent.
// -----------------------------------------------------------------------------
module tb_bringup_uart_checker;

    localparam int         CPB  = 13;
    localparam logic [7:0] EXP  = 8'h45;
    localparam int         TO   = 1500;
    localparam int         LAT  = 2 + CPB / 2 + 9 * CPB + 1;
    localparam int         STK  = 20 * CPB;
    localparam int         HOLD = 200;
    localparam int         GAP  = 2 * CPB;
`ifdef BRINGUP_UART_CHECKER_STUCK_DETECT_EN
    localparam logic       EXP_STUCK = 1'b1;
`else
    localparam logic       EXP_STUCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        clr = 1'b0;
    logic        byte_valid;
    logic [7:0]  byte_out;
    logic        match;
    logic        frame_error;
    logic [15:0] match_count;
    logic [15:0] mismatch_count;
    logic [15:0] error_count;
    logic        alive;
    logic        stuck_low;

    always #5 clk = ~clk;

    bringup_uart_checker #(
        .CLOCKS_PER_BAUD (CPB),
        .EXPECTED        (EXP),
        .TIMEOUT_CLOCKS  (TO)
    ) dut (
        .clock            (clk),
        .reset            (rst),
        .rx_i             (rx),
        .clear_i          (clr),
        .byte_valid_o     (byte_valid),
        .byte_o           (byte_out),
        .match_o          (match),
        .frame_error_o    (frame_error),
        .match_count_o    (match_count),
        .mismatch_count_o (mismatch_count),
        .error_count_o    (error_count),
        .alive_o          (alive),
        .stuck_low_o      (stuck_low)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] b;
        logic       m;
    } strobe_t;

    strobe_t q[$];
    strobe_t mon_s;
    int checks = 0;
    int errors = 0;

    // Reference state: plain integer counts, clamped only when compared.
    int         m_mc, m_mm, m_ec;
    logic       m_fe;
    logic [7:0] m_byte;
    int         m_lm;

    always @(negedge clk) begin
        if (byte_valid) begin
            mon_s.c = cyc;
            mon_s.b = byte_out;
            mon_s.m = match;
            q.push_back(mon_s);
        end
        if (match && !byte_valid) begin
            errors++;
            $display("FAIL stray_match: match_o=1 with byte_valid_o=0 at cycle %0d", cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int clamp16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic exp_alive();
        return (m_lm >= 0) && (cyc >= m_lm + 1) && (cyc <= m_lm + TO);
    endfunction

    task automatic model_reset();
        m_mc = 0; m_mm = 0; m_ec = 0; m_fe = 1'b0; m_byte = 8'h00; m_lm = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic at_cycle(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_byte"},     byte_out,       m_byte);
        chk({tag, "_matches"},  match_count,    clamp16(m_mc));
        chk({tag, "_mismatch"}, mismatch_count, clamp16(m_mm));
        chk({tag, "_errors"},   error_count,    clamp16(m_ec));
        chk({tag, "_frame_err"}, frame_error,   m_fe);
        chk({tag, "_alive"},    alive,          exp_alive());
    endtask

    // Called just after a rising edge. Pulses clear_i so that it is sampled
    // at edge t0+clr_rel; asserts reset at the start of bit rst_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int clr_rel, input int rst_bit);
        logic [9:0] bits;
        int t0;
        bits = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == rst_bit) begin
                rx = 1'b1; rst = 1'b1;
                idle(2);
                rst = 1'b0;
                return;
            end
            rx = bits[i];
            for (int c = 0; c < CPB; c++) begin
                clr = ((cyc - t0 + 1) == clr_rel);
                @(posedge clk); #1;
            end
        end
        clr = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop, input int clr_rel,
                             output int n, output logic m);
        int t0;
        strobe_t s;
        q.delete();
        t0 = cyc;
        send_frame(d, stop, clr_rel, -1);
        if (!stop) begin
            idle(HOLD);
            rx = 1'b1;
        end
        idle(GAP);
        n = q.size();
        m = 1'b0;
        if (n > 0) begin
            s = q.pop_front();
            m = s.m;
            chk("latency", s.c - t0, LAT);
            chk("strobe_byte", s.b, d);
        end
        if (stop) begin
            m_byte = d;
            if (d == EXP) begin m_mc++; m_lm = t0 + LAT; end
            else m_mm++;
        end else begin
            m_ec++; m_fe = 1'b1;
        end
        if (clr_rel >= 0) begin
            m_mc = 0; m_mm = 0; m_ec = 0; m_fe = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         n;
        logic       m;
        int         mc, mm, ec;
    } row_t;

    function automatic row_t mk(input logic [7:0] d, input logic stop, input int n,
                                input logic m, input int mc, input int mm, input int ec);
        row_t r;
        r.d = d; r.stop = stop; r.n = n; r.m = m; r.mc = mc; r.mm = mm; r.ec = ec;
        return r;
    endfunction

    initial begin
        row_t       tbl [10];
        int         n;
        logic       m;
        int         t0;
        int         rel;
        logic [7:0] d;
        logic       stop;

        tbl[0] = mk(8'h45, 1'b1, 1, 1'b1, 1, 0, 0);
        tbl[1] = mk(8'h49, 1'b1, 1, 1'b0, 1, 1, 0);
        tbl[2] = mk(8'h45, 1'b0, 0, 1'b0, 1, 1, 1);
        tbl[3] = mk(8'h45, 1'b1, 1, 1'b1, 2, 1, 1);
        tbl[4] = mk(8'h00, 1'b1, 1, 1'b0, 2, 2, 1);
        tbl[5] = mk(8'hFF, 1'b1, 1, 1'b0, 2, 3, 1);
        tbl[6] = mk(8'h44, 1'b1, 1, 1'b0, 2, 4, 1);
        tbl[7] = mk(8'hC5, 1'b1, 1, 1'b0, 2, 5, 1);
        tbl[8] = mk(8'hA5, 1'b0, 0, 1'b0, 2, 5, 2);
        tbl[9] = mk(8'h45, 1'b1, 1, 1'b1, 3, 5, 2);

        model_reset();
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_match", match, 1'b0);
        chk("rst_stuck", stuck_low, 1'b0);
        chk_state("rst");
        rst = 1'b0;
        idle(2);

        // Short low glitch on an idle line
        q.delete();
        rx = 1'b0; idle(3); rx = 1'b1;
        idle(12 * CPB);
        chk("glitch_strobes", q.size(), 0);
        chk_state("glitch");

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].d, tbl[i].stop, -1, n, m);
            chk($sformatf("row%0d_strobes", i), n, tbl[i].n);
            chk($sformatf("row%0d_match", i), m, tbl[i].m);
            chk($sformatf("row%0d_mc", i), match_count, tbl[i].mc);
            chk($sformatf("row%0d_mm", i), mismatch_count, tbl[i].mm);
            chk($sformatf("row%0d_ec", i), error_count, tbl[i].ec);
            chk_state($sformatf("row%0d", i));
        end

        // Reset in the middle of bit 4
        q.delete();
        send_frame(8'h45, 1'b1, -1, 4);
        model_reset();
        idle(12 * CPB);
        chk("midrst_strobes", q.size(), 0);
        chk_state("midrst");
        run_frame(8'h45, 1'b1, -1, n, m);
        chk("after_rst_strobes", n, 1);
        chk("after_rst_match", m, 1'b1);
        chk_state("after_rst");

        // Alive timeout at exactly TO cycles after the match window opens
        at_cycle(m_lm + TO);
        chk("alive_last", alive, 1'b1);
        at_cycle(m_lm + TO + 1);
        chk("alive_drop", alive, 1'b0);

        // Saturation from a preloaded match counter
        @(negedge clk);
        force dut.r_match_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_match_count;
        @(posedge clk); #1;
        m_mc = 65534;
        run_frame(8'h45, 1'b1, -1, n, m);
        chk("sat1_match", match_count, 16'hFFFF);
        run_frame(8'h45, 1'b1, -1, n, m);
        chk("sat2_match", match_count, 16'hFFFF);
        chk_state("sat");

        // Clear alone, then clear coinciding with an increment
        run_frame(8'h12, 1'b1, -1, n, m);
        run_frame(8'h45, 1'b0, -1, n, m);
        chk_state("pre_clear");
        clr = 1'b1; idle(1); clr = 1'b0;
        m_mc = 0; m_mm = 0; m_ec = 0; m_fe = 1'b0;
        chk_state("clear");
        run_frame(8'h45, 1'b1, LAT, n, m);
        chk("clr_inc_strobes", n, 1);
        chk("clr_inc_match", m, 1'b1);
        chk_state("clr_inc");

        // Line held low well beyond 20 bit periods
        q.delete();
        t0 = cyc;
        rx = 1'b0;
        at_cycle(t0 + 1 + STK);
        chk("stuck_before", stuck_low, 1'b0);
        at_cycle(t0 + 2 + STK);
        chk("stuck_rise", stuck_low, EXP_STUCK);
        at_cycle(t0 + 2 + STK + 50);
        rx = 1'b1;
        rel = cyc;
        at_cycle(rel + 2);
        chk("stuck_hold", stuck_low, EXP_STUCK);
        at_cycle(rel + 3);
        chk("stuck_fall", stuck_low, 1'b0);
        m_ec++; m_fe = 1'b1;
        idle(GAP);
        chk("stuck_strobes", q.size(), 0);
        chk_state("stuck");

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            d    = ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            run_frame(d, stop, -1, n, m);
            chk($sformatf("rnd%0d_strobes", i), n, stop ? 1 : 0);
            chk($sformatf("rnd%0d_match", i), m, stop && (d == EXP));
            chk_state($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
